sd_spi_cmd_engine: RTL and testbench

Parametrised SD-card SPI command engine: the next generation of `sd_card_cmd`. It frames any 6-bit command index with a 32-bit argument and computes CRC7 on the fly. It drives its own SCLK/MOSI/CS_N and captures a variable-length response (R1 plus up to 4 trailing bytes, e.g. R3/R7), with a bounded NCR timeout. It sits between the SD init/read/write sequencer and the SD pins; data-block transfers belong to a separate block, which takes over while CS is held.

---
 rtl/sd_card_pkg.sv | 29 ++
 rtl/sd_crc7.sv | 22 ++
 rtl/sd_spi_cmd_engine.sv | 191 +++++++++++++++++++
 tb/tb_sd_spi_cmd_engine.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sd_card_pkg.sv
// Shared definitions for the SD-card SPI command path: command indices,
// CRC7 polynomial, R1 bit positions and the command engine state encoding.
package sd_card_pkg;

  localparam logic [5:0] CMD0  = 6'd0;
  localparam logic [5:0] CMD8  = 6'd8;
  localparam logic [5:0] CMD16 = 6'd16;
  localparam logic [5:0] CMD17 = 6'd17;
  localparam logic [5:0] CMD24 = 6'd24;
  localparam logic [5:0] CMD41 = 6'd41;
  localparam logic [5:0] CMD55 = 6'd55;
  localparam logic [5:0] CMD58 = 6'd58;

  localparam logic [6:0] CRC7_POLY = 7'h09;

  localparam int R1_IDLE        = 0;
  localparam int R1_ILLEGAL_CMD = 2;
  localparam int R1_CRC_ERR     = 3;

  typedef enum logic [2:0] {IDLE, SEND, WAIT, READ, TRAIL, DONE} state_t;

  // 0 means a plain R1; anything past the engine's capacity is cut back.
  function automatic logic [2:0] clamp_resp_bytes(input logic [2:0] n, input int max_n);
    if (n == 3'd0) return 3'd1;
    if (int'(n) > max_n) return 3'(max_n);
    return n;
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), one message bit per enabled clock.
module sd_crc7
  import sd_card_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_bit,
  output logic [6:0] o_crc
);

  logic fb;
  assign fb = i_bit ^ o_crc[6];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       o_crc <= '0;
    else if (i_clr)  o_crc <= '0;
    else if (i_en)   o_crc <= {o_crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  end

endmodule

// File: rtl/sd_spi_cmd_engine.sv
// SD SPI command engine: frames a command with CRC7, drives SCLK/MOSI/CS_N
// in mode 0 and captures an R1 plus up to four trailing response bytes.
module sd_spi_cmd_engine
  import sd_card_pkg::*;
#(
  parameter int CLK_DIV        = 4,
  parameter int NCR_MAX        = 8,
  parameter int RESP_BYTES_MAX = 5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_send_cmd,
  input  logic [5:0]  i_cmd_index,
  input  logic [31:0] i_cmd_arg,
  input  logic [2:0]  i_resp_bytes,
  input  logic        i_keep_cs,
  input  logic        i_miso,
  output logic        o_sclk,
  output logic        o_mosi,
  output logic        o_cs_n,
  output logic        o_busy,
  output logic        o_cmd_done,
  output logic        o_timeout,
  output logic [7:0]  o_response_status,
  output logic [31:0] o_response_ext
);

  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int NCR_BITS = NCR_MAX * 8;
  localparam int NCR_W    = $clog2(NCR_BITS + 1);

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [5:0]       bit_cnt;
  logic [NCR_W-1:0] ncr_cnt;
  logic [38:0]      frame_sr;
  logic [38:0]      resp_sr;
  logic [2:0]       resp_bytes;
  logic             keep_cs;
  logic [6:0]       crc;

  logic        active, tick, rise, fall;
  logic        crc_clr, crc_en;
  logic [39:0] resp_next;
  logic [5:0]  resp_bits;
  logic [7:0]  status_next;
  logic [31:0] ext_mask;

  assign active    = state inside {SEND, WAIT, READ, TRAIL};
  assign tick      = active && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign rise      = tick && !o_sclk;
  assign fall      = tick && o_sclk;
  assign crc_clr   = (state == IDLE) && i_send_cmd;
  // The card samples each bit on the rise; the CRC follows the same bits,
  // so it has settled a half-period before the first CRC bit is driven.
  assign crc_en    = (state == SEND) && rise && (bit_cnt < 6'd40);
  assign resp_next = {resp_sr, i_miso};
  assign resp_bits = {resp_bytes, 3'b000};

  // R1 sits just above the trailing bytes; everything above it is still zero.
  always_comb begin
    status_next = 8'(resp_next >> (resp_bits - 6'd8));
    ext_mask    = (32'h1 << (resp_bits - 6'd8)) - 32'h1;
  end

  sd_crc7 u_crc7 (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (crc_clr),
    .i_en  (crc_en),
    .i_bit (o_mosi),
    .o_crc (crc)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state             <= IDLE;
      div_cnt           <= '0;
      bit_cnt           <= '0;
      ncr_cnt           <= '0;
      frame_sr          <= '0;
      resp_sr           <= '0;
      resp_bytes        <= 3'd1;
      keep_cs           <= 1'b0;
      o_sclk            <= 1'b0;
      o_mosi            <= 1'b1;
      o_cs_n            <= 1'b1;
      o_busy            <= 1'b0;
      o_cmd_done        <= 1'b0;
      o_timeout         <= 1'b0;
      o_response_status <= 8'hFF;
      o_response_ext    <= '0;
    end else begin
      o_cmd_done <= 1'b0;

      if (active) begin
        if (tick) begin
          div_cnt <= '0;
          o_sclk  <= ~o_sclk;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end else begin
        div_cnt <= '0;
        o_sclk  <= 1'b0;
      end

      case (state)
        IDLE: if (i_send_cmd) begin
          frame_sr   <= {1'b1, i_cmd_index, i_cmd_arg};
          resp_bytes <= clamp_resp_bytes(i_resp_bytes, RESP_BYTES_MAX);
          keep_cs    <= i_keep_cs;
          resp_sr    <= '0;
          bit_cnt    <= '0;
          o_busy     <= 1'b1;
          o_cs_n     <= 1'b0;
          o_mosi     <= 1'b0;
          state      <= SEND;
        end

        // bit_cnt = position of the bit now on MOSI (0 = start bit).
        SEND: if (fall) begin
          if (bit_cnt == 6'd47) begin
            o_mosi  <= 1'b1;
            bit_cnt <= '0;
            ncr_cnt <= '0;
            state   <= WAIT;
          end else begin
            bit_cnt <= bit_cnt + 6'd1;
            if (bit_cnt == 6'd39) begin
              o_mosi   <= crc[6];
              frame_sr <= {crc[5:0], 1'b1, 32'h0};
            end else begin
              o_mosi   <= frame_sr[38];
              frame_sr <= {frame_sr[37:0], 1'b0};
            end
          end
        end

        WAIT: if (rise) begin
          if (!i_miso) begin
            resp_sr <= resp_next[38:0];
            bit_cnt <= 6'd1;
            state   <= READ;
          end else if (ncr_cnt == NCR_W'(NCR_BITS - 1)) begin
            o_timeout         <= 1'b1;
            o_response_status <= 8'hFF;
            o_response_ext    <= '0;
            bit_cnt           <= '0;
            state             <= TRAIL;
          end else begin
            ncr_cnt <= ncr_cnt + NCR_W'(1);
          end
        end

        READ: if (rise) begin
          resp_sr <= resp_next[38:0];
          if (bit_cnt == resp_bits - 6'd1) begin
            o_timeout         <= 1'b0;
            o_response_status <= status_next;
            o_response_ext    <= resp_next[31:0] & ext_mask;
            bit_cnt           <= '0;
            state             <= TRAIL;
          end else begin
            bit_cnt <= bit_cnt + 6'd1;
          end
        end

        // Entered on a rise: the first fall closes the last response bit,
        // the next eight are the trailing clocks.
        TRAIL: if (fall) begin
          if (bit_cnt == 6'd8) begin
            if (!keep_cs) o_cs_n <= 1'b1;
            state <= DONE;
          end else begin
            bit_cnt <= bit_cnt + 6'd1;
          end
        end

        DONE: begin
          o_cmd_done <= 1'b1;
          o_busy     <= 1'b0;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
// Directed bench for sd_spi_cmd_engine with a bit-level SPI card model.
module tb_sd_spi_cmd_engine;
  import sd_card_pkg::*;

  localparam int CLK_DIV = 2, NCR_MAX = 8, RESP_BYTES_MAX = 5;

  logic        clk = 1'b0, rst = 1'b1, send = 1'b0, keep = 1'b0, miso = 1'b1;
  logic [5:0]  idx = '0;
  logic [31:0] arg = '0;
  logic [2:0]  rb  = 3'd1;
  logic        sclk, mosi, cs_n, busy, done, tmo;
  logic [7:0]  status;
  logic [31:0] ext;

  int checks = 0, failures = 0;
  int cyc = 0, lat = 0, rise_cnt = 0, rise_base = 0, last_rise_cyc = 0;
  int period_err = 0, mosi_hi_err = 0, done_cnt = 0;
  int card_w = 0, card_len = 0;
  logic [7:0]  card_data [5];
  logic [47:0] frame_cap = '0;
  logic        cs_d1 = 1'b1, cs_d2 = 1'b1;

  sd_spi_cmd_engine #(.CLK_DIV(CLK_DIV), .NCR_MAX(NCR_MAX), .RESP_BYTES_MAX(RESP_BYTES_MAX)) dut (
    .i_clk(clk), .i_rst(rst), .i_send_cmd(send), .i_cmd_index(idx), .i_cmd_arg(arg),
    .i_resp_bytes(rb), .i_keep_cs(keep), .i_miso(miso),
    .o_sclk(sclk), .o_mosi(mosi), .o_cs_n(cs_n), .o_busy(busy), .o_cmd_done(done),
    .o_timeout(tmo), .o_response_status(status), .o_response_ext(ext)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;
  always @(negedge clk) if (done === 1'b1) done_cnt = done_cnt + 1;

  // Capture the 48 command bits as the card sees them, then expect MOSI idle high.
  always @(posedge sclk) begin
    int n;
    rise_cnt = rise_cnt + 1;
    n = rise_cnt - rise_base;
    if (n <= 48) frame_cap = {frame_cap[46:0], mosi};
    else if (mosi !== 1'b1) mosi_hi_err = mosi_hi_err + 1;
    if (n > 1 && (cyc - last_rise_cyc) != 2 * CLK_DIV) period_err = period_err + 1;
    last_rise_cyc = cyc;
  end

  // Card: idles card_w ones after the command, then card_len bytes, MSB first.
  always @(negedge sclk or posedge cs_n) begin
    int k;
    if (cs_n === 1'b1) miso = 1'b1;
    else begin
      k = rise_cnt - rise_base + 1 - 49 - card_w;
      if (k >= 0 && k < card_len * 8) miso = card_data[k / 8][7 - (k % 8)];
      else miso = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk); #1; lat++;
  endtask

  task automatic set_card(input int w, input int len, input logic [39:0] bytes);
    card_w = w; card_len = len;
    for (int i = 0; i < 5; i++) card_data[i] = bytes[39 - 8 * i -: 8];
  endtask

  task automatic start_cmd(input logic [5:0] c, input logic [31:0] a, input logic [2:0] r, input logic k);
    @(negedge clk);
    idx = c; arg = a; rb = r; keep = k; send = 1'b1; rise_base = rise_cnt;
    lat = 0;
    step();
    send = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    while (done !== 1'b1 && lat < budget) begin
      cs_d2 = cs_d1; cs_d1 = cs_n;
      step();
    end
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL done_wait got=no_done exp=done_within_%0d", budget); end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({sclk, mosi, cs_n, busy, done, tmo} !== 6'b011000) begin failures++;
      $display("FAIL reset_ctrl got=%b exp=011000", {sclk, mosi, cs_n, busy, done, tmo}); end
    checks++; if (status !== 8'hFF) begin failures++; $display("FAIL reset_status got=%h exp=ff", status); end
    checks++; if (ext !== 32'h0) begin failures++; $display("FAIL reset_ext got=%h exp=0", ext); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_cmd0();
    int d0;
    set_card(11, 1, 40'h01_0000_0000);
    d0 = done_cnt;
    start_cmd(CMD0, 32'h0, 3'd1, 1'b0);
    checks++; if ({cs_n, busy, sclk} !== 3'b010) begin failures++;
      $display("FAIL cmd0_accept got=%b exp=010", {cs_n, busy, sclk}); end
    step();
    checks++; if (sclk !== 1'b0) begin failures++; $display("FAIL cmd0_sclk_pre got=%b exp=0", sclk); end
    step();
    checks++; if (sclk !== 1'b1) begin failures++; $display("FAIL cmd0_first_rise got=%b exp=1", sclk); end
    wait_done(2000);
    checks++; if (lat !== 302) begin failures++; $display("FAIL cmd0_latency got=%0d exp=302", lat); end
    checks++; if (frame_cap !== 48'h40_0000_0000_95) begin failures++; $display("FAIL cmd0_frame got=%h exp=400000000095", frame_cap); end
    checks++; if ({tmo, status, ext} !== {1'b0, 8'h01, 32'h0}) begin failures++;
      $display("FAIL cmd0_resp got=%b/%h/%h exp=0/01/00000000", tmo, status, ext); end
    checks++; if ({busy, cs_n} !== 2'b01) begin failures++; $display("FAIL cmd0_idle got=%b exp=01", {busy, cs_n}); end
    repeat (4) step();
    checks++; if (done_cnt - d0 !== 1 || done !== 1'b0) begin failures++;
      $display("FAIL cmd0_done_pulses got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_cmd8();
    set_card(2, 5, 40'h01_0000_01AA);
    start_cmd(CMD8, 32'h0000_01AA, 3'd5, 1'b0);
    wait_done(2000);
    checks++; if (lat !== 394) begin failures++; $display("FAIL cmd8_latency got=%0d exp=394", lat); end
    checks++; if (frame_cap !== 48'h48_0000_01AA_87) begin failures++; $display("FAIL cmd8_frame got=%h exp=48000001aa87", frame_cap); end
    checks++; if (status !== 8'h01) begin failures++; $display("FAIL cmd8_status got=%h exp=01", status); end
    checks++; if (ext !== 32'h0000_01AA) begin failures++; $display("FAIL cmd8_ext got=%h exp=000001aa", ext); end
  endtask

  task automatic test_timeout();
    set_card(0, 0, 40'h0);
    start_cmd(CMD58, 32'h0, 3'd5, 1'b0);
    while (lat < 100) step();
    checks++; if ({tmo, status, ext} !== {1'b0, 8'h01, 32'h1AA}) begin failures++;
      $display("FAIL tmo_hold got=%b/%h/%h exp=0/01/000001aa", tmo, status, ext); end
    wait_done(2000);
    checks++; if (lat !== 482) begin failures++; $display("FAIL tmo_latency got=%0d exp=482", lat); end
    checks++; if (frame_cap !== 48'h7A_0000_0000_FD) begin failures++; $display("FAIL tmo_frame got=%h exp=7a00000000fd", frame_cap); end
    checks++; if ({tmo, status, ext} !== {1'b1, 8'hFF, 32'h0}) begin failures++;
      $display("FAIL tmo_resp got=%b/%h/%h exp=1/ff/00000000", tmo, status, ext); end
    checks++; if ({cs_n, cs_d1, cs_d2} !== 3'b110) begin failures++;
      $display("FAIL tmo_cs_release got=%b exp=110", {cs_n, cs_d1, cs_d2}); end
  endtask

  task automatic test_start_bit_offset();
    set_card(3, 5, 40'h00_1234_5678);
    start_cmd(CMD55, 32'h0, 3'd7, 1'b0);
    wait_done(2000);
    checks++; if (lat !== 398) begin failures++; $display("FAIL offset_latency got=%0d exp=398", lat); end
    checks++; if (frame_cap !== 48'h77_0000_0000_65) begin failures++; $display("FAIL offset_frame got=%h exp=770000000065", frame_cap); end
    checks++; if ({tmo, status, ext} !== {1'b0, 8'h00, 32'h1234_5678}) begin failures++;
      $display("FAIL offset_resp got=%b/%h/%h exp=0/00/12345678", tmo, status, ext); end
    checks++; if (period_err !== 0 || mosi_hi_err !== 0) begin failures++;
      $display("FAIL sclk_timing got=%0d/%0d exp=0/0", period_err, mosi_hi_err); end
  endtask

  task automatic test_busy_ignore();
    set_card(0, 1, 40'h01_0000_0000);
    start_cmd(CMD41, 32'h4000_0000, 3'd1, 1'b0);
    while (lat < 20) step();
    @(negedge clk);
    idx = CMD0; arg = 32'hFFFF_FFFF; send = 1'b1;
    step();
    send = 1'b0;
    wait_done(2000);
    checks++; if (lat !== 258) begin failures++; $display("FAIL busy_ign_latency got=%0d exp=258", lat); end
    checks++; if (frame_cap !== 48'h69_4000_0000_77) begin failures++; $display("FAIL busy_ign_frame got=%h exp=694000000077", frame_cap); end
    checks++; if (status !== 8'h01) begin failures++; $display("FAIL busy_ign_status got=%h exp=01", status); end
  endtask

  task automatic test_reset_mid_wait();
    set_card(0, 0, 40'h0);
    start_cmd(CMD55, 32'h0, 3'd1, 1'b0);
    while (lat < 250) step();
    #2 rst = 1'b1;
    #1;
    checks++; if ({sclk, mosi, cs_n, busy, done, tmo} !== 6'b011000) begin failures++;
      $display("FAIL rst_mid_ctrl got=%b exp=011000", {sclk, mosi, cs_n, busy, done, tmo}); end
    checks++; if ({status, ext} !== {8'hFF, 32'h0}) begin failures++;
      $display("FAIL rst_mid_resp got=%h/%h exp=ff/00000000", status, ext); end
    @(negedge clk); rst = 1'b0;
    set_card(0, 1, 40'h01_0000_0000);
    start_cmd(CMD55, 32'h0, 3'd1, 1'b0);
    while (lat < 257) step();
    idx = CMD0; send = 1'b1;   // overlaps the DONE cycle
    step();
    send = 1'b0;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL after_rst_done got=%b exp=1 at lat 258", done); end
    checks++; if (status !== 8'h01 || frame_cap !== 48'h77_0000_0000_65) begin failures++;
      $display("FAIL after_rst_resp got=%h/%h exp=01/770000000065", status, frame_cap); end
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL done_cycle_ignore got=%b exp=0", busy); end
    repeat (3) step();
    checks++; if ({busy, cs_n} !== 2'b01) begin failures++; $display("FAIL done_cycle_idle got=%b exp=01", {busy, cs_n}); end
  endtask

  task automatic test_keep_cs();
    set_card(1, 1, 40'h00_0000_0000);
    start_cmd(CMD17, 32'h0, 3'd0, 1'b1);
    wait_done(2000);
    checks++; if (lat !== 262) begin failures++; $display("FAIL keep_latency got=%0d exp=262", lat); end
    checks++; if ({cs_n, cs_d1, cs_d2} !== 3'b000) begin failures++;
      $display("FAIL keep_cs_low got=%b exp=000", {cs_n, cs_d1, cs_d2}); end
    checks++; if (status !== 8'h00) begin failures++; $display("FAIL keep_status got=%h exp=00", status); end
    repeat (10) step();
    checks++; if (cs_n !== 1'b0) begin failures++; $display("FAIL keep_cs_hold got=%b exp=0", cs_n); end
    set_card(0, 2, 40'h00_4200_0000);
    start_cmd(6'd13, 32'h0, 3'd2, 1'b0);
    wait_done(2000);
    checks++; if (lat !== 290) begin failures++; $display("FAIL cmd13_latency got=%0d exp=290", lat); end
    checks++; if ({cs_n, cs_d1, cs_d2} !== 3'b110) begin failures++;
      $display("FAIL cmd13_cs_release got=%b exp=110", {cs_n, cs_d1, cs_d2}); end
    checks++; if ({status, ext} !== {8'h00, 32'h42}) begin failures++;
      $display("FAIL cmd13_resp got=%h/%h exp=00/00000042", status, ext); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=no_finish exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cmd0();
    test_cmd8();
    test_timeout();
    test_start_bit_offset();
    test_busy_ignore();
    test_reset_mid_wait();
    test_keep_cs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
